// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//
// Generic APB3 storage target: a word-addressed memory array of DEPTH words
// of DATA_W bits with a programmable number of wait states per transfer.
// Out-of-range and misaligned accesses complete with pslverr=1; such writes
// leave the memory untouched and such reads return ERR_DATA.
//
// Optional feature macro: APB_MEM_PSTRB_EN
//   defined   -> pstrb port exists, writes update only strobed bytes
//   undefined -> no pstrb port, every write updates the whole word
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   presetn  in   synchronous active-low reset
//   psel     in   slave select
//   penable  in   access phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_W]
//   pwdata   in   write data [DATA_W]
//   pstrb    in   byte write strobes [DATA_W/8] (APB_MEM_PSTRB_EN only)
//   prdata   out  read data, registered [DATA_W]
//   pready   out  transfer completion, registered
//   pslverr  out  error response, registered, valid with pready
//   busy     out  transfer sitting in wait states, registered
// ---------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH       = 32,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OB    = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  localparam logic [DATA_W-1:0] ERR_WORD  = DATA_W'(ERR_DATA);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01
  } state_t;

  // Any address bit above the array's byte span means out of range (no
  // aliasing); any set byte-offset bit means misaligned. For DATA_W=8 the
  // offset mask is zero, so misalignment can never be flagged.
  function automatic logic addr_error(input logic [ADDR_W-1:0] a);
    logic oor;
    logic mis;
    oor = (a >> (OB + IW)) != '0;
    mis = (a & ADDR_W'(BYTES - 1)) != '0;
    return oor | mis;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BYTES-1:0]  strb
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_p1;
  logic              wr_p1;
  logic              err_p1;

  logic              capture;
  logic              complete;
  logic              pready_d;
  logic              busy_d;
  logic              pslverr_d;

  logic [IW-1:0]     rd_idx;
  logic              rd_wr;
  logic              rd_err;
  logic [BYTES-1:0]  strb_eff;
  logic              setup_err;

`ifdef APB_MEM_PSTRB_EN
  assign strb_eff = pstrb;
`else
  assign strb_eff = '1;
`endif

  assign setup_err = addr_error(paddr);

  // The registered outputs for the pready cycle are loaded one edge early.
  // With zero wait states that edge is the setup edge itself, so the read
  // source comes straight from the bus instead of the captured copy.
  assign rd_idx = capture ? paddr[OB+IW-1:OB] : idx_p1;
  assign rd_wr  = capture ? pwrite            : wr_p1;
  assign rd_err = capture ? setup_err         : err_p1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    complete  = 1'b0;
    pready_d  = 1'b0;
    busy_d    = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d   = ACCESS;
          cnt_d     = WAIT_LOAD;
          capture   = 1'b1;
          pready_d  = ZERO_WAIT;
          busy_d    = !ZERO_WAIT;
          pslverr_d = ZERO_WAIT && setup_err;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // pready cycle: the transfer finishes at the edge ending it
          complete = 1'b1;
          state_d  = IDLE;
        end else if (!psel || !penable) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d     = cnt_q - 4'd1;
          pready_d  = (cnt_q == 4'd1);
          busy_d    = (cnt_q != 4'd1);
          pslverr_d = (cnt_q == 4'd1) && err_p1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---- control / output register stage ----
  always_ff @(posedge clk) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pready  <= 1'b0;
      busy    <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      busy    <= busy_d;
      pslverr <= pslverr_d;
      if (pready_d && !rd_wr) begin
        prdata <= rd_err ? ERR_WORD : mem[rd_idx];
      end
    end
  end

  // ---- setup capture stage ----
  always_ff @(posedge clk) begin
    if (capture) begin
      idx_p1 <= paddr[OB+IW-1:OB];
      wr_p1  <= pwrite;
      err_p1 <= setup_err;
    end
  end

  // ---- memory write stage (pwdata/pstrb sampled at the completion edge) ----
  always_ff @(posedge clk) begin
    if (presetn && complete && wr_p1 && !err_p1) begin
      mem[idx_p1] <= merge_bytes(mem[idx_p1], pwdata, strb_eff);
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// Testbench for apb_mem_slave: instance a uses WAIT_CYCLES=2, instance b uses
// WAIT_CYCLES=0. A word-array model tracks the expected memory contents.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] paddr, pwdata;
`ifdef APB_MEM_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [2][32];

  always #5 clk = ~clk;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .presetn(presetn), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a), .busy(busy_a)
  );

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .presetn(presetn), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b), .busy(busy_b)
  );

  function automatic logic rdy(input int d);
    return (d == 0) ? pready_a : pready_b;
  endfunction
  function automatic logic bsy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic serr(input int d);
    return (d == 0) ? pslverr_a : pslverr_b;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? prdata_a : prdata_b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  // One complete transfer on instance d, checking every cycle's handshake,
  // the response, and updating the model. Returns at the negedge of the
  // pready cycle so the next call issues a back-to-back setup phase.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int          waits;
    bit          err;
    logic [31:0] exp_rd, prev, nw;
    logic [3:0]  es;
    logic [4:0]  wi;
    waits  = (d == 0) ? 2 : 0;
    err    = (addr >= 32'd128) || (addr[1:0] != 2'b00);
    wi     = addr[6:2];
    exp_rd = err ? 32'hDEAD_BEEF : model[d][wi];
`ifdef APB_MEM_PSTRB_EN
    es = strb;
`else
    es = 4'hF;
`endif
    @(posedge clk); #1;
    psel_a = (d == 0); psel_b = (d == 1); penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_MEM_PSTRB_EN
    pstrb = strb;
`endif
    @(negedge clk);
    chk("setup_pready", 32'(rdy(d)), 32'd0);
    chk("setup_busy", 32'(bsy(d)), 32'd0);
    prev = rdat(d);
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= waits + 1; c++) begin
      @(negedge clk);
      chk("access_busy", 32'(bsy(d)), 32'(c <= waits));
      chk("access_pready", 32'(rdy(d)), 32'(c == waits + 1));
    end
    chk("pslverr", 32'(serr(d)), 32'(err));
    if (!wr) chk("prdata", rdat(d), exp_rd);
    else     chk("prdata_hold", rdat(d), prev);
    if (wr && !err) begin
      nw = model[d][wi];
      for (int b = 0; b < 4; b++) if (es[b]) nw[b*8 +: 8] = data[b*8 +: 8];
      model[d][wi] = nw;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_MEM_PSTRB_EN
    pstrb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1 presetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_prdata", rdat(d), 32'd0);
      chk("rst_pready", 32'(rdy(d)), 32'd0);
      chk("rst_pslverr", 32'(serr(d)), 32'd0);
      chk("rst_busy", 32'(bsy(d)), 32'd0);
    end

    // Fill both memories so every later read has a defined expectation.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 32; w++) xfer(d, 1'b1, 32'(w * 4), $urandom, 4'hF);

    // Directed write/read.
    xfer(0, 1'b1, 32'h08, 32'h1234_5678, 4'hF);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'hF);
    chk("wr_rd_0x08", model[0][2], 32'h1234_5678);

    // Out-of-range read/write, then word 0 must be unchanged.
    xfer(0, 1'b0, 32'h80, 32'h0, 4'hF);
    xfer(0, 1'b1, 32'h80, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'hF);

    // Misaligned on the zero-wait instance, plus a far out-of-range address.
    xfer(1, 1'b0, 32'h06, 32'h0, 4'hF);
    xfer(1, 1'b1, 32'h0001_0000, 32'h0BAD_0BAD, 4'hF);
    xfer(1, 1'b0, 32'h00, 32'h0, 4'hF);
    idle();

    // Abort: psel dropped in access cycle 1 of a write.
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_0000;
    @(posedge clk); #1;
    psel_a = 1'b0; penable = 1'b1;
    @(negedge clk);
    chk("abort_c1_pready", 32'(pready_a), 32'd0);
    @(posedge clk); #1;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_pready", 32'(pready_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
    xfer(0, 1'b1, 32'h14, 32'h5A5A_A5A5, 4'hF);
    xfer(0, 1'b0, 32'h14, 32'h0, 4'hF);
    idle();

    // Reset held for two cycles during an active write to 0x0C.
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    penable = 1'b1; presetn = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    presetn = 1'b1; psel_a = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("midrst_prdata", prdata_a, 32'd0);
    chk("midrst_pready", 32'(pready_a), 32'd0);
    chk("midrst_pslverr", 32'(pslverr_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_prdata_b", prdata_b, 32'd0);
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'hF);

`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'b1111);
    xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000);
    chk("strb_merge", model[0][8], 32'h11BB_33DD);
    xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'b1010);
`endif

    // Randomized traffic across both instances, mostly aligned addresses.
    for (int n = 0; n < 200; n++) begin
      int          d;
      bit          wr;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 159);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
